rca_seq_adder: RTL and testbench

- Multi-cycle wide adder that reuses one 4-bit ripple-carry slice to add two WIDTH-bit operands, one slice per clock.
- Slices run LSB-first. A register carries the carry from each slice into the next.
- Valid/ready handshakes on the input and output sides. Sits between an operand producer and a result consumer where area matters more than latency.
- Handles one operation at a time; there is no overlap between operations.

---
 rtl/rca_pkg.sv | 17 +
 rtl/rca4_slice.sv | 22 ++
 rtl/rca_seq_adder.sv | 137 +++++++++++++
 tb/tb_rca_seq_adder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared types and constants for the sequential ripple-carry adder.
// Slice width is fixed at 4 bits; the operand width is a parameter of the top.
package rca_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/rca4_slice.sv
// Combinational 4-bit ripple-carry adder.
// A chain of four full-adder cells with carry-in and carry-out.
module rca4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule

// File: rtl/rca_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple-carry slice, one slice per clock.
// The operation runs LSB-first with a registered carry between slices.
module rca_seq_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic [SLICE_W-1:0] w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_run;
    logic               w_last;

    rca4_slice u_slice (
        .a    (r_a[SLICE_W-1:0]),
        .b    (r_b[SLICE_W-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready is gated by rst_n so it stays low for the whole reset pulse.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_sum_nxt = r_sum;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_sum_nxt[i*SLICE_W +: SLICE_W] = w_s;
            end
        end
    end

    // cout keeps the previous result until the last slice of the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> SLICE_W;
            r_b     <= r_b >> SLICE_W;
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            r_sum   <= w_sum_nxt;
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench for rca_seq_adder: a WIDTH=16 instance and a WIDTH=4 instance.
module tb_rca_seq_adder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        in_valid, out_ready, cin;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;

    logic        n4_in_valid, n4_out_ready, n4_cin;
    logic [3:0]  n4_a, n4_b;
    logic        n4_in_ready, n4_out_valid, n4_cout, n4_busy;
    logic [3:0]  n4_sum;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] bb_a [3] = '{16'h0001, 16'h0003, 16'h8000};
    logic [15:0] bb_b [3] = '{16'h0002, 16'h0004, 16'h8000};
    logic [15:0] bb_s [3] = '{16'h0003, 16'h0007, 16'h0000};
    logic        bb_c [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rca_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    rca_seq_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n4_in_valid),
        .in_ready  (n4_in_ready),
        .a         (n4_a),
        .b         (n4_b),
        .cin       (n4_cin),
        .out_valid (n4_out_valid),
        .out_ready (n4_out_ready),
        .sum       (n4_sum),
        .cout      (n4_cout),
        .busy      (n4_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the current point until out_valid, bounded.
    task automatic wait_ov(input string tag, input int lat_exp);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(lat_exp));
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic [15:0] es, input logic ec);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        tick();
        in_valid = 1'b0;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " in_ready in RUN"}, 32'(in_ready), 32'd0);
        wait_ov(tag, 4);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " busy in DONE"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
        check({tag, " busy after hs"}, 32'(busy), 32'd0);
        check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int t_prev;
        int n;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        cin          = 1'b0;
        a            = '0;
        b            = '0;
        n4_in_valid  = 1'b0;
        n4_out_ready = 1'b0;
        n4_cin       = 1'b0;
        n4_a         = '0;
        n4_b         = '0;
        t_prev       = 0;

        #2 rst_n = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst n4 in_ready", 32'(n4_in_ready), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        run_op("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

        // Backpressure: result held while new operands are offered.
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_ov("bp", 4);
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp sum held", 32'(sum), 32'h5555);
            check("bp cout held", 32'(cout), 32'd0);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp hs out_valid", 32'(out_valid), 32'd0);
        check("bp hs in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp new accept busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_ov("bp_next", 4);
        check("bp_next sum", 32'(sum), 32'h2222);
        check("bp_next cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        a         = bb_a[0];
        b         = bb_b[0];
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b2b busy", 32'(busy), 32'd1);
            if (k < 2) begin
                a = bb_a[k+1];
                b = bb_b[k+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_ov("b2b", 4);
            check("b2b sum", 32'(sum), 32'(bb_s[k]));
            check("b2b cout", 32'(cout), 32'(bb_c[k]));
            if (k > 0) check("b2b spacing", 32'(cyc - t_prev), 32'd6);
            t_prev = cyc;
            tick();
            check("b2b hs out_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        run_op("max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Reset in the second RUN cycle; cout still holds 1 from the previous op.
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid-run busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        tick();
        check("abort in_ready held", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort release in_ready", 32'(in_ready), 32'd1);
        run_op("post_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // WIDTH=4 instance: single RUN cycle.
        n4_in_valid = 1'b1;
        n4_a        = 4'hF;
        n4_b        = 4'h1;
        n4_cin      = 1'b1;
        tick();
        n4_in_valid = 1'b0;
        check("w4 busy", 32'(n4_busy), 32'd1);
        n = 0;
        while (n4_out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("w4 out_valid", 32'(n4_out_valid), 32'd1);
        check("w4 latency", 32'(n), 32'd1);
        check("w4 sum", 32'(n4_sum), 32'h1);
        check("w4 cout", 32'(n4_cout), 32'd1);
        n4_out_ready = 1'b1;
        tick();
        n4_out_ready = 1'b0;
        check("w4 hs out_valid", 32'(n4_out_valid), 32'd0);
        check("w4 hs in_ready", 32'(n4_in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
